fir_tdm_sequencer: RTL and testbench
====================================

// Module: fir_tdm_sequencer
// PURPOSE
//  Time-multiplexed FIR controller. Accepts one input sample per valid/ready
//  handshake and sequences a single shared multiply-accumulate over NTAPS taps.
//  Computes y[n] = sum h[k]*x[n-k] from an internal sample ring buffer and a
//  run-time-writable coefficient bank. Sits between the sample source and the
//  downstream consumer wherever a parallel FIR costs too many multipliers.
// PARAMETERS
//  NTAPS  4   number of taps (>=2); ring-buffer and coefficient-bank depth
//  DW     16  sample and output width, signed
//  CW     16  coefficient width, signed
//  SHIFT  0   arithmetic right shift applied to accumulator before saturation
//  ACCW   DW+CW+$clog2(NTAPS)  accumulator width (derived localparam, not overridable)
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous reset, active-high
//  s_valid     in   1      input sample valid
//  s_ready     out  1      block can accept a sample
//  s_data      in   DW     input sample, signed
//  m_valid     out  1      output sample valid
//  m_ready     in   1      consumer accepts output
//  m_data      out  DW     filtered output, signed, saturated
//  coef_we     in   1      coefficient write request
//  coef_ready  out  1      coefficient write will be taken this cycle
//  coef_addr   in   clog2(NTAPS)  tap index k
//  coef_wdata  in   CW     coefficient value, signed
//  busy        out  1      high while in MAC state
// BEHAVIOUR
//  - Reset (async): state IDLE; s_ready=1, m_valid=0, m_data=0, busy=0, coef_ready=1.
//    Ring buffer cleared to 0; wr_ptr=0; acc=0; coef[k] reset to k+1.
//  - States: IDLE -> MAC -> OUT -> IDLE.
//  - IDLE: s_ready=1. On s_valid&&s_ready edge: write s_data to buf[wr_ptr],
//    clear acc, k=0, go to MAC.
//  - MAC: exactly NTAPS cycles, one tap per edge: acc += buf[(wr_ptr-k) mod NTAPS]*coef[k],
//    k=0..NTAPS-1. Tap k=0 uses the newly written sample. On the last tap,
//    wr_ptr <= wr_ptr+1 (wraps NTAPS-1 -> 0), m_data <= sat(acc_final >>> SHIFT),
//    go to OUT.
//  - OUT: m_valid=1; m_data held stable until m_valid&&m_ready; then IDLE.
//  - Latency: m_valid rises NTAPS edges after the accepting edge. Min period
//    NTAPS+2 cycles per sample (accept, NTAPS MAC, one OUT cycle).
//  - s_ready=0 in MAC and OUT; s_valid there is ignored; upstream must hold it.
//  - Arithmetic: products DW+CW signed, full-precision accumulate in ACCW (no
//    overflow possible). Shift is arithmetic. Saturation clamps to
//    [-2^(DW-1), 2^(DW-1)-1].
//  - Coefficients: coef_ready = !busy. Write is taken on coef_we&&coef_ready.
//    In MAC, coef_we is dropped (no queueing); the writer must retry.
//    A write in the same IDLE edge as a sample accept applies to that sample.
//    A write in OUT applies to the next sample. coef_addr >= NTAPS is ignored.
//  - Reset mid-operation: abort the computation, no partial output, all state
//    returns to reset values, including coefficients.
// STRUCTURE
//  - fir_pkg: state enum (IDLE/MAC/OUT), sat() function, acc-width helper.
//  - Sub-module fir_mac_unit: signed multiply-accumulate with clr/en inputs
//    and an ACCW-bit accumulator output.
//  - Top level holds the FSM, tap counter, ring buffer, coefficient bank and
//    output register.
// TESTING (NTAPS=4, DW=CW=16, SHIFT=0 unless noted)
//  1 Reset, then impulse x=1,0,0,0,0 -> m_data 1,2,3,4,0; s_ready=1 after reset.
//  2 Step x=100 held for 5 samples -> 100,300,600,1000,1000.
//  3 m_ready=0 for 5 cycles in OUT -> m_data stable, s_ready=0, no sample taken.
//  4 coef all 0x7FFF, four x=0x7FFF -> 0x7FFF. Four x=0x8000 -> 0x8000 (saturation).
//  5 coef_we during MAC -> coef_ready=0, value unchanged. In IDLE write coef[0]=-1,
//    then impulse -> first output -1.
//  6 rst asserted at MAC cycle 2 -> m_valid=0 at once. After release, impulse gives 1,2,3,4.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR sequencer.
package fir_pkg;

    // Sequencer states: wait for a sample, walk the taps, present the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_e;

    // Working width used by the saturation helper; wide enough for any
    // accumulator this block is expected to be built with.
    localparam int SAT_W = 64;

    // Accumulator width that makes overflow impossible for NTAPS full-scale products.
    function automatic int acc_width(input int dw, input int cw, input int ntaps);
        return dw + cw + $clog2(ntaps);
    endfunction

    // Clamp a signed value to the range of a w-bit signed number.
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                    input int                      w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Single shared signed multiply-accumulate. acc_next_o is the accumulator
// value including the product currently on the inputs, so the caller can
// capture the final sum on the same edge as the last tap.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int AW = 34
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic signed [DW-1:0] sample_i,
    input  logic signed [CW-1:0] coef_i,
    output logic signed [AW-1:0] acc_next_o
);

    logic signed [DW+CW-1:0] prod_s;
    logic signed [AW-1:0]    prod_ext_s;
    logic signed [AW-1:0]    acc_q;

    // Operands are sign-extended to the product width so the modular product is exact.
    assign prod_s     = {{CW{sample_i[DW-1]}}, sample_i} * {{DW{coef_i[CW-1]}}, coef_i};
    assign prod_ext_s = {{(AW-DW-CW){prod_s[DW+CW-1]}}, prod_s};
    assign acc_next_o = acc_q + prod_ext_s;

    // Accumulator register: cleared at sample accept, advanced once per tap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_next_o;
        end else begin
            acc_q <= acc_q;
        end
    end

endmodule

// File: rtl/fir_tdm_sequencer.sv
// Time-multiplexed FIR: one sample per handshake, NTAPS MAC cycles through a
// shared multiplier, saturated result held until the consumer takes it.
module fir_tdm_sequencer
    import fir_pkg::*;
#(
    parameter  int NTAPS = 4,
    parameter  int DW    = 16,
    parameter  int CW    = 16,
    parameter  int SHIFT = 0,
    localparam int PW    = $clog2(NTAPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [DW-1:0] m_data,
    input  logic                 coef_we,
    output logic                 coef_ready,
    input  logic [PW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_wdata,
    output logic                 busy
);

    localparam int ACCW = acc_width(DW, CW, NTAPS);

    fir_state_e            state_q;
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         tap_q;
    logic signed [DW-1:0]  smp_q  [NTAPS];
    logic signed [CW-1:0]  coef_q [NTAPS];
    logic                  s_ready_q;
    logic                  m_valid_q;
    logic signed [DW-1:0]  m_data_q;
    logic                  busy_q;
    logic                  coef_ready_q;

    logic [PW-1:0]         rd_idx_s;
    logic                  accept_s;
    logic                  mac_en_s;
    logic                  coef_hit_s;
    logic [31:0]           coef_addr_ext_s;
    logic signed [ACCW-1:0]  acc_next_s;
    logic signed [ACCW-1:0]  acc_shift_s;
    logic signed [SAT_W-1:0] acc_wide_s;
    logic signed [SAT_W-1:0] acc_sat_s;
    logic signed [DW-1:0]    m_data_d;

    assign accept_s        = (state_q == ST_IDLE) && s_valid && s_ready_q;
    assign mac_en_s        = (state_q == ST_MAC);
    assign coef_addr_ext_s = 32'(coef_addr);
    assign coef_hit_s      = coef_we && coef_ready_q && (coef_addr_ext_s < 32'(NTAPS));

    // Ring-buffer read index for tap k: (wr_ptr - k) mod NTAPS, valid for any NTAPS.
    always_comb begin
        rd_idx_s = '0;
        if (tap_q <= wr_ptr_q) begin
            rd_idx_s = wr_ptr_q - tap_q;
        end else begin
            rd_idx_s = PW'(({1'b0, wr_ptr_q} + (PW+1)'(NTAPS)) - {1'b0, tap_q});
        end
    end

    fir_mac_unit #(
        .DW (DW),
        .CW (CW),
        .AW (ACCW)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept_s),
        .en_i       (mac_en_s),
        .sample_i   (smp_q[rd_idx_s]),
        .coef_i     (coef_q[tap_q]),
        .acc_next_o (acc_next_s)
    );

    // Final scaling: arithmetic shift, then clamp to the output range.
    assign acc_shift_s = acc_next_s >>> SHIFT;
    assign acc_wide_s  = {{(SAT_W-ACCW){acc_shift_s[ACCW-1]}}, acc_shift_s};
    assign acc_sat_s   = sat(acc_wide_s, DW);
    assign m_data_d    = DW'(acc_sat_s);

    // Sequencer FSM with ring buffer, coefficient bank and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            tap_q        <= '0;
            s_ready_q    <= 1'b1;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            busy_q       <= 1'b0;
            coef_ready_q <= 1'b1;
            for (int i = 0; i < NTAPS; i++) begin
                smp_q[i]  <= '0;
                coef_q[i] <= CW'(i + 1);
            end
        end else begin
            // Coefficient writes are only open outside MAC, so a write on the
            // accept edge lands before the first tap reads the bank.
            if (coef_hit_s) begin
                coef_q[coef_addr] <= coef_wdata;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        smp_q[wr_ptr_q] <= s_data;
                        tap_q           <= '0;
                        s_ready_q       <= 1'b0;
                        busy_q          <= 1'b1;
                        coef_ready_q    <= 1'b0;
                        state_q         <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (tap_q == PW'(NTAPS - 1)) begin
                        wr_ptr_q     <= (wr_ptr_q == PW'(NTAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
                        m_data_q     <= m_data_d;
                        m_valid_q    <= 1'b1;
                        busy_q       <= 1'b0;
                        coef_ready_q <= 1'b1;
                        state_q      <= ST_OUT;
                    end else begin
                        tap_q <= tap_q + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    s_ready_q    <= 1'b1;
                    m_valid_q    <= 1'b0;
                    busy_q       <= 1'b0;
                    coef_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign s_ready    = s_ready_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign busy       = busy_q;
    assign coef_ready = coef_ready_q;

endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// Self-checking bench for fir_tdm_sequencer: a reference FIR model pushes the
// expected output when each sample is accepted; outputs are popped and compared.
module tb_fir_tdm_sequencer;

    localparam int NTAPS = 4;
    localparam int SHIFT = 0;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [15:0] s_data = 16'sd0;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic signed [15:0] m_data;
    logic               coef_we = 1'b0;
    logic               coef_ready;
    logic [1:0]         coef_addr = 2'd0;
    logic signed [15:0] coef_wdata = 16'sd0;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [15:0] exp_q[$];
    logic signed [15:0] hist_m[NTAPS];
    logic signed [15:0] coef_m[NTAPS];

    always #5 clk = ~clk;

    fir_tdm_sequencer #(.NTAPS(NTAPS), .DW(16), .CW(16), .SHIFT(SHIFT)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .coef_we    (coef_we),
        .coef_ready (coef_ready),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .busy       (busy)
    );

    task automatic model_reset();
        for (int i = 0; i < NTAPS; i++) begin
            hist_m[i] = 16'sd0;
            coef_m[i] = 16'(i + 1);
        end
    endtask

    function automatic logic signed [15:0] model_push(input logic signed [15:0] x);
        longint acc;
        for (int i = NTAPS - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
        hist_m[0] = x;
        acc = 0;
        for (int k = 0; k < NTAPS; k++) acc += longint'(hist_m[k]) * longint'(coef_m[k]);
        acc = acc >>> SHIFT;
        if (acc > 32767) return 16'sh7FFF;
        else if (acc < -32768) return 16'sh8000;
        else return 16'(acc);
    endfunction

    task automatic send_sample(input logic signed [15:0] x);
        int waited = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = x;
        while (s_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout: s_ready=%b required 1", s_ready);
        end else begin
            exp_q.push_back(model_push(x));
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic collect_output(input string name);
        int waited = 0;
        logic signed [15:0] e;
        @(negedge clk);
        while (m_valid !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: m_valid=%b required 1", name, m_valid);
        end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_unexpected: m_data=%0d with empty scoreboard", name, m_data);
        end else begin
            e = exp_q.pop_front();
            if (m_data !== e) begin
                n_fail++;
                $display("FAIL %s: m_data=%0d required %0d", name, m_data, e);
            end
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic write_coef(input logic [1:0] a, input logic signed [15:0] d);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = d;
        n_checks++;
        if (coef_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL coef_ready_idle: coef_ready=%b required 1", coef_ready);
        end else begin
            coef_m[a] = d;
        end
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({s_ready, m_valid, busy, coef_ready} !== 4'b1001 || m_data !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_state: s_ready=%b m_valid=%b busy=%b coef_ready=%b m_data=%0d required 1 0 0 1 0",
                     s_ready, m_valid, busy, coef_ready, m_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_impulse();
        send_sample(16'sd1);
        repeat (NTAPS - 1) @(posedge clk);
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || busy !== 1'b1 || coef_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: m_valid=%b busy=%b coef_ready=%b required 0 1 0", m_valid, busy, coef_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_rise: m_valid=%b required 1", m_valid);
        end
        collect_output("impulse0");
        for (int i = 1; i < 5; i++) begin
            send_sample(16'sd0);
            collect_output("impulse");
        end
    endtask

    task automatic test_step();
        for (int i = 0; i < 5; i++) begin
            send_sample(16'sd100);
            collect_output("step");
        end
    endtask

    task automatic test_backpressure();
        logic signed [15:0] e;
        send_sample(16'sd50);
        repeat (NTAPS) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_valid: m_valid=%b required 1", m_valid);
        end
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 16'sd7;
            n_checks++;
            if (m_data !== e || s_ready !== 1'b0 || m_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_stable: m_data=%0d s_ready=%b m_valid=%b required %0d 0 1", m_data, s_ready, m_valid, e);
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        n_checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: m_valid=%b s_ready=%b required 0 1", m_valid, s_ready);
        end
        send_sample(16'sd0);
        collect_output("after_hold");
    endtask

    task automatic test_saturation();
        for (int k = 0; k < NTAPS; k++) write_coef(2'(k), 16'sh7FFF);
        for (int i = 0; i < 4; i++) begin
            send_sample(16'sh7FFF);
            collect_output("sat_pos");
        end
        for (int i = 0; i < 4; i++) begin
            send_sample(16'sh8000);
            collect_output("sat_neg");
        end
        send_sample(16'sh8000);
        repeat (NTAPS) @(posedge clk);
        #1;
        n_checks++;
        if (m_data !== 16'sh8000) begin
            n_fail++;
            $display("FAIL sat_floor: m_data=%0d required -32768", m_data);
        end
        collect_output("sat_neg_last");
    endtask

    task automatic test_coef_write();
        send_sample(16'sd5);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = 2'd0;
        coef_wdata = 16'sd99;
        n_checks++;
        if (coef_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL coef_blocked: coef_ready=%b busy=%b required 0 1", coef_ready, busy);
        end
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        collect_output("coef_dropped");
        for (int k = 0; k < NTAPS; k++) write_coef(2'(k), 16'(k + 1));
        write_coef(2'd0, -16'sd1);
        for (int i = 0; i < NTAPS; i++) begin
            send_sample(16'sd0);
            collect_output("coef_flush");
        end
        send_sample(16'sd1);
        repeat (NTAPS) @(posedge clk);
        #1;
        n_checks++;
        if (m_data !== -16'sd1) begin
            n_fail++;
            $display("FAIL coef_neg_tap0: m_data=%0d required -1", m_data);
        end
        collect_output("coef_impulse");
    endtask

    task automatic test_reset_mid_mac();
        send_sample(16'sd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({m_valid, busy, s_ready, coef_ready} !== 4'b0011 || m_data !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_abort: m_valid=%b busy=%b s_ready=%b coef_ready=%b m_data=%0d required 0 0 1 1 0",
                     m_valid, busy, s_ready, coef_ready, m_data);
        end
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send_sample(16'sd1);
        collect_output("post_reset");
        for (int i = 1; i < NTAPS; i++) begin
            send_sample(16'sd0);
            collect_output("post_reset");
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_step();
        test_backpressure();
        test_saturation();
        test_coef_write();
        test_reset_mid_mac();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
